// File: rtl/fixed_range_pkg.sv
// Shared definitions for the fixed-point inverse-sqrt front end: Q1.15 root-two
// constants (also consumed by the range-augmentation stage) and a generic
// leading-one priority encoder.
package fixed_range_pkg;

    localparam int CONST_WIDTH = 16;
    // sqrt(2) and 1/sqrt(2) in Q1.15
    localparam logic [CONST_WIDTH-1:0] SQRT2  = 16'hB505;
    localparam logic [CONST_WIDTH-1:0] ISQRT2 = 16'h5A82;

    // Widest datapath the priority encoder supports; narrower callers zero-extend.
    localparam int MAX_WIDTH = 64;

    // Index of the highest set bit; 0 when the value is zero.
    function automatic int msb_index(input logic [MAX_WIDTH-1:0] value);
        msb_index = 0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (value[i]) begin
                msb_index = i;
            end
        end
    endfunction

endpackage

// File: rtl/fixed_leading_one_detector.sv
// Combinational leading-one detector: reports the index of the highest set bit
// of data and flags an all-zero input (for which msb reads 0).
module fixed_leading_one_detector
    import fixed_range_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]         data,
    output logic [$clog2(WIDTH)-1:0] msb,
    output logic                     zero
);

    localparam int MSB_WIDTH = $clog2(WIDTH);

    logic [MAX_WIDTH-1:0] data_ext;

    assign data_ext = MAX_WIDTH'(data);

    // Priority-encode the zero-extended input and flag the all-zero case.
    always_comb begin
        msb  = MSB_WIDTH'(msb_index(data_ext));
        zero = ~|data;
    end

endmodule

// File: rtl/fixed_range_reduction_pipe.sv
// Range-reduction front stage of the inverse-sqrt datapath. Normalises an
// unsigned fixed-point sample into Q1.(WIDTH-1) and reports its MSB index.
// Two-stage valid/ready pipeline: S1 leading-one detect, S2 barrel shift.
// Optional build macro FIXED_RANGE_REDUCTION_ZERO_FLAG_EN adds data_out_zero,
// which is high when the emitted sample was zero.
module fixed_range_reduction_pipe
    import fixed_range_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FRAC_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     data_in_valid,
    output logic                     data_in_ready,
    output logic [WIDTH-1:0]         data_out,
    output logic [$clog2(WIDTH)-1:0] data_out_msb,
    output logic                     data_out_valid,
`ifdef FIXED_RANGE_REDUCTION_ZERO_FLAG_EN
    output logic                     data_out_zero,
`endif
    input  logic                     data_out_ready
);

    localparam int MSB_WIDTH = $clog2(WIDTH);

    // S1: raw sample plus its leading-one information
    logic                 s1_valid_reg, s1_valid_next;
    logic [WIDTH-1:0]     s1_data_reg,  s1_data_next;
    logic [MSB_WIDTH-1:0] s1_msb_reg,   s1_msb_next;
    logic                 s1_zero_reg,  s1_zero_next;

    // S2: normalised sample
    logic                 s2_valid_reg, s2_valid_next;
    logic [WIDTH-1:0]     s2_data_reg,  s2_data_next;
    logic [MSB_WIDTH-1:0] s2_msb_reg,   s2_msb_next;
    logic                 s2_zero_reg,  s2_zero_next;

    logic                 s1_adv;
    logic                 in_ready;
    logic [MSB_WIDTH-1:0] lod_msb;
    logic                 lod_zero;
    logic [MSB_WIDTH-1:0] shift_amt;

    fixed_leading_one_detector #(
        .WIDTH (WIDTH)
    ) u_lod (
        .data (data_in),
        .msb  (lod_msb),
        .zero (lod_zero)
    );

    // Handshake and next-state for both stages; S1 moves into S2 on the same
    // edge S2 drains so a full pipe keeps streaming without bubbles.
    always_comb begin
        s1_adv    = !s2_valid_reg || data_out_ready;
        in_ready  = !s1_valid_reg || s1_adv;
        shift_amt = MSB_WIDTH'(WIDTH - 1) - s1_msb_reg;

        s1_valid_next = s1_valid_reg;
        s1_data_next  = s1_data_reg;
        s1_msb_next   = s1_msb_reg;
        s1_zero_next  = s1_zero_reg;
        s2_valid_next = s2_valid_reg;
        s2_data_next  = s2_data_reg;
        s2_msb_next   = s2_msb_reg;
        s2_zero_next  = s2_zero_reg;

        if (in_ready) begin
            s1_valid_next = data_in_valid;
            if (data_in_valid) begin
                s1_data_next = data_in;
                s1_msb_next  = lod_msb;
                s1_zero_next = lod_zero;
            end
        end

        if (s1_adv) begin
            s2_valid_next = s1_valid_reg;
            if (s1_valid_reg) begin
                // A zero sample shifts to zero, so no special case is needed.
                s2_data_next = s1_data_reg << shift_amt;
                s2_msb_next  = s1_msb_reg;
                s2_zero_next = s1_zero_reg;
            end
        end
    end

    // Pipeline registers; reset discards everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
            s1_msb_reg   <= '0;
            s1_zero_reg  <= 1'b0;
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
            s2_msb_reg   <= '0;
            s2_zero_reg  <= 1'b0;
        end else begin
            s1_valid_reg <= s1_valid_next;
            s1_data_reg  <= s1_data_next;
            s1_msb_reg   <= s1_msb_next;
            s1_zero_reg  <= s1_zero_next;
            s2_valid_reg <= s2_valid_next;
            s2_data_reg  <= s2_data_next;
            s2_msb_reg   <= s2_msb_next;
            s2_zero_reg  <= s2_zero_next;
        end
    end

    assign data_in_ready  = in_ready;
    assign data_out       = s2_data_reg;
    assign data_out_msb   = s2_msb_reg;
    assign data_out_valid = s2_valid_reg;
`ifdef FIXED_RANGE_REDUCTION_ZERO_FLAG_EN
    assign data_out_zero  = s2_zero_reg;
`endif

    // A nonzero result must be normalised into [1,2).
    a_norm_msb: assert property (@(posedge clk) disable iff (rst)
        (s2_valid_reg && !s2_zero_reg) |-> s2_data_reg[WIDTH-1]);

    // The downstream exponent (msb - FRAC_WIDTH) must stay within the input's range.
    a_exp_range: assert property (@(posedge clk) disable iff (rst)
        s2_valid_reg |-> ((int'(s2_msb_reg) - FRAC_WIDTH) <= (WIDTH - 1 - FRAC_WIDTH)));

endmodule

// File: tb/tb_fixed_range_reduction_pipe.sv
// Self-checking bench for fixed_range_reduction_pipe (WIDTH=16, FRAC_WIDTH=8).
// A scoreboard queue holds expected outputs pushed at each input transfer and
// popped at each output transfer.
module tb_fixed_range_reduction_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in;
    logic        data_in_valid;
    logic        data_in_ready;
    logic [15:0] data_out;
    logic [3:0]  data_out_msb;
    logic        data_out_valid;
    logic        data_out_ready;
`ifdef FIXED_RANGE_REDUCTION_ZERO_FLAG_EN
    logic        data_out_zero;
`endif

    always #5 clk = ~clk;

    fixed_range_reduction_pipe #(
        .WIDTH      (16),
        .FRAC_WIDTH (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_msb   (data_out_msb),
        .data_out_valid (data_out_valid),
`ifdef FIXED_RANGE_REDUCTION_ZERO_FLAG_EN
        .data_out_zero  (data_out_zero),
`endif
        .data_out_ready (data_out_ready)
    );

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  m;
        logic        z;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          acc_count = 0;
    int          out_count = 0;
    logic        held_valid = 1'b0;
    logic [15:0] held_data;
    logic [3:0]  held_msb;

    // Reference normalisation: find the top set bit, shift it up to bit 15.
    function automatic exp_t model(input logic [15:0] v);
        exp_t e;
        logic [3:0] top;
        top = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                top = 4'(i);
                break;
            end
        end
        e.m = top;
        e.z = (v == 16'h0000);
        e.d = v << (4'd15 - top);
        return e;
    endfunction

    // Monitor: record input transfers, check output transfers and stall stability.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held_valid = 1'b0;
        end else begin
            if (data_in_valid && data_in_ready) begin
                sb.push_back(model(data_in));
                acc_count++;
            end
            if (held_valid && data_out_valid) begin
                n_checks++;
                if (data_out !== held_data || data_out_msb !== held_msb)
                    $display("FAIL stall_hold: data_out=%h msb=%0d, required %h msb=%0d",
                             data_out, data_out_msb, held_data, held_msb);
                else
                    n_pass++;
            end
            if (data_out_valid && data_out_ready) begin
                out_count++;
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_unexpected: got data_out=%h msb=%0d with nothing expected",
                             data_out, data_out_msb);
                end else begin
                    e = sb.pop_front();
`ifdef FIXED_RANGE_REDUCTION_ZERO_FLAG_EN
                    if (data_out !== e.d || data_out_msb !== e.m || data_out_zero !== e.z)
                        $display("FAIL sb_data: got %h msb=%0d zero=%b, required %h msb=%0d zero=%b",
                                 data_out, data_out_msb, data_out_zero, e.d, e.m, e.z);
`else
                    if (data_out !== e.d || data_out_msb !== e.m)
                        $display("FAIL sb_data: got %h msb=%0d, required %h msb=%0d",
                                 data_out, data_out_msb, e.d, e.m);
`endif
                    else begin
                        n_pass++;
                        $display("out %h -> data_out=%h msb=%0d", e.d, data_out, data_out_msb);
                    end
                end
                held_valid = 1'b0;
            end else if (data_out_valid) begin
                held_valid = 1'b1;
                held_data  = data_out;
                held_msb   = data_out_msb;
            end else begin
                held_valid = 1'b0;
            end
        end
    end

    // Present one sample until it is accepted; keep leaves valid high for streaming.
    task automatic send(input logic [15:0] v, input bit keep);
        int b;
        b = 0;
        data_in       = v;
        data_in_valid = 1'b1;
        @(negedge clk);
        while (!data_in_ready && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (b >= 200) begin
            n_checks++;
            $display("FAIL send_timeout: data_in_ready=%b, required 1", data_in_ready);
        end
        @(posedge clk);
        #1;
        if (!keep) data_in_valid = 1'b0;
    endtask

    // Called one tick after the transfer edge; returns edges until data_out_valid.
    task automatic measure_latency(output int lat);
        lat = 1;
        while (!data_out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic wait_drain();
        int b;
        b = 0;
        while ((sb.size() != 0 || data_out_valid) && b < 200) begin
            @(negedge clk);
            b++;
        end
        n_checks++;
        if (sb.size() != 0)
            $display("FAIL drain: %0d outputs outstanding, required 0", sb.size());
        else
            n_pass++;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        data_in        = 16'h0;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (data_out_valid !== 1'b0 || data_out !== 16'h0 || data_out_msb !== 4'd0)
            $display("FAIL reset_outputs: valid=%b data=%h msb=%0d, required 0 0000 0",
                     data_out_valid, data_out, data_out_msb);
        else
            n_pass++;
`ifdef FIXED_RANGE_REDUCTION_ZERO_FLAG_EN
        n_checks++;
        if (data_out_zero !== 1'b0)
            $display("FAIL reset_zero: data_out_zero=%b, required 0", data_out_zero);
        else
            n_pass++;
`endif
        rst = 1'b0;
        #1;
        n_checks++;
        if (data_in_ready !== 1'b1)
            $display("FAIL reset_ready: data_in_ready=%b, required 1", data_in_ready);
        else
            n_pass++;
        $display("reset released");
    endtask

    task automatic test_normalise();
        logic [15:0] vin [5];
        logic [15:0] vout[5];
        logic [3:0]  vmsb[5];
        int lat;
        vin  = '{16'h0100, 16'h0003, 16'hFFFF, 16'h8000, 16'h0000};
        vout = '{16'h8000, 16'hC000, 16'hFFFF, 16'h8000, 16'h0000};
        vmsb = '{4'd8, 4'd1, 4'd15, 4'd15, 4'd0};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            send(vin[i], 1'b0);
            measure_latency(lat);
            n_checks++;
            if (lat != 2)
                $display("FAIL latency_%h: %0d cycles, required 2", vin[i], lat);
            else
                n_pass++;
            n_checks++;
            if (data_out !== vout[i] || data_out_msb !== vmsb[i])
                $display("FAIL norm_%h: data_out=%h msb=%0d, required %h msb=%0d",
                         vin[i], data_out, data_out_msb, vout[i], vmsb[i]);
            else
                n_pass++;
`ifdef FIXED_RANGE_REDUCTION_ZERO_FLAG_EN
            n_checks++;
            if (data_out_zero !== (vin[i] == 16'h0))
                $display("FAIL zero_flag_%h: data_out_zero=%b, required %b",
                         vin[i], data_out_zero, (vin[i] == 16'h0));
            else
                n_pass++;
`endif
            wait_drain();
        end
    endtask

    task automatic test_backpressure();
        int acc_base;
        int out_base;
        @(posedge clk);
        #1;
        acc_base = acc_count;
        out_base = out_count;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(16'(1 << i), i < 3);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                data_out_ready = 1'b0;
                @(negedge clk);
                n_checks++;
                if (data_in_ready !== 1'b0 || acc_count - acc_base != 2)
                    $display("FAIL bp_ready_fall: data_in_ready=%b accepted=%0d, required 0 and 2",
                             data_in_ready, acc_count - acc_base);
                else
                    n_pass++;
                repeat (5) @(posedge clk);
                #1;
                data_out_ready = 1'b1;
            end
        join
        wait_drain();
        n_checks++;
        if (out_count - out_base != 4)
            $display("FAIL bp_count: %0d outputs, required 4", out_count - out_base);
        else
            n_pass++;
    endtask

    task automatic test_toggle();
        int  out_base;
        bit  done;
        done = 1'b0;
        @(posedge clk);
        #1;
        out_base = out_count;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(16'($urandom_range(0, 16'hFFFF)), i < 9);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    data_out_ready = ~data_out_ready;
                end
            end
        join
        data_out_ready = 1'b1;
        wait_drain();
        n_checks++;
        if (out_count - out_base != 10)
            $display("FAIL toggle_count: %0d outputs, required 10", out_count - out_base);
        else
            n_pass++;
    endtask

    task automatic test_reset_midstream();
        int  lat;
        bit  stale;
        @(posedge clk);
        #1;
        data_out_ready = 1'b0;
        send(16'h0020, 1'b1);
        send(16'h0400, 1'b0);
        n_checks++;
        if (data_out_valid !== 1'b1)
            $display("FAIL mid_inflight: data_out_valid=%b, required 1", data_out_valid);
        else
            n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (data_out_valid !== 1'b0 || data_out !== 16'h0)
            $display("FAIL mid_async: valid=%b data=%h, required 0 0000", data_out_valid, data_out);
        else
            n_pass++;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        data_out_ready = 1'b1;
        stale = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (data_out_valid) stale = 1'b1;
        end
        n_checks++;
        if (stale)
            $display("FAIL mid_stale: data_out_valid=1 after reset, required 0");
        else
            n_pass++;
        @(posedge clk);
        #1;
        send(16'h0006, 1'b0);
        measure_latency(lat);
        n_checks++;
        if (lat != 2 || data_out !== 16'hC000 || data_out_msb !== 4'd2)
            $display("FAIL mid_restart: lat=%0d data=%h msb=%0d, required 2 C000 2",
                     lat, data_out, data_out_msb);
        else
            n_pass++;
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_normalise();
        test_backpressure();
        test_toggle();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
